// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package multdiv_pkg;

    localparam int          ITER      = 32;
    localparam logic [5:0]  LAST_ITER = 6'(ITER - 1);
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with rippled group carries.
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic [31:0] bw_and,
    output logic [31:0] bw_or,
    output logic        isZero
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | ((&p[4*k +: 2]) & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | ((&p[4*k+1 +: 2]) & g[4*k])
                     | ((&p[4*k +: 3]) & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+2 +: 2]) & g[4*k+1])
                     | ((&p[4*k+1 +: 3]) & g[4*k]) | ((&p[4*k +: 4]) & c[4*k]);
        end
    end

    assign sum    = p ^ c[31:0];
    assign cout   = c[32];
    assign bw_and = a & b;
    assign bw_or  = a | b;
    assign isZero = (sum == 32'd0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Signed 32-bit multiply (radix-2 Booth) / divide (restoring on magnitudes) sequencer
// sharing a single cla_32 across 32 iterations.
//
// state | meaning
// IDLE  | waiting for op_mult / op_div
// MULT  | Booth iteration: conditional add into hi, then shift {hi, lo, q-1}
// DIV   | restoring step on {R, Q}
// FIX   | conditional negate of the quotient
// DONE  | result_rdy strobe
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_mult,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    state_t           state, state_nx;
    logic [5:0]       iter_cnt;
    logic [WIDTH-1:0] hi, lo, m;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic             qm1, neg, div_ovf;
    logic             accept_mult, accept_div, last_iter;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic [WIDTH-1:0] unused_bw_and, unused_bw_or;
    logic             unused_is_zero;

    assign accept_mult = (state == ST_IDLE) && op_mult;
    assign accept_div  = (state == ST_IDLE) && op_div && !op_mult;
    assign last_iter   = (iter_cnt == LAST_ITER);
    assign mag_a       = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    assign mag_b       = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

    // Shared adder operand mux: Booth add/sub, trial subtract, or 0 - Q.
    always_comb begin
        add_a   = hi;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            ST_MULT: begin
                case ({lo[0], qm1})
                    2'b01:   add_b = m;
                    2'b10: begin
                        add_b   = ~m;
                        add_cin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_DIV: begin
                add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
                add_b   = ~m;
                add_cin = 1'b1;
            end
            ST_FIX: begin
                add_a   = '0;
                add_b   = ~lo;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    cla_32 u_cla (
        .a      (add_a),
        .b      (add_b),
        .cin    (add_cin),
        .sum    (add_sum),
        .cout   (add_cout),
        .bw_and (unused_bw_and),
        .bw_or  (unused_bw_or),
        .isZero (unused_is_zero)
    );

    // The shifted-in sign is the 33-bit sum sign so M = INT_MIN stays exact.
    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        case (state)
            ST_MULT: begin
                hi_nx = {add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout, add_sum[WIDTH-1:1]};
                lo_nx = {add_sum[0], lo[WIDTH-1:1]};
            end
            ST_DIV: begin
                if (hi[WIDTH-1] || add_cout) begin
                    hi_nx = add_sum;
                    lo_nx = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_nx = add_a;
                    lo_nx = {lo[WIDTH-2:0], 1'b0};
                end
            end
            ST_FIX: begin
                if (neg) lo_nx = add_sum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        result_rdy = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept_mult)     state_nx = ST_MULT;
                else if (accept_div) state_nx = (operand_b == '0) ? ST_DONE : ST_DIV;
            end
            ST_MULT: if (last_iter) state_nx = ST_DONE;
            ST_DIV:  if (last_iter) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: begin
                result_rdy = 1'b1;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi        <= '0;
            lo        <= '0;
            m         <= '0;
            qm1       <= 1'b0;
            neg       <= 1'b0;
            div_ovf   <= 1'b0;
            iter_cnt  <= '0;
            result    <= '0;
            exception <= 1'b0;
        end else if (accept_mult) begin
            hi        <= '0;
            lo        <= operand_b;
            m         <= operand_a;
            qm1       <= 1'b0;
            iter_cnt  <= '0;
            result    <= '0;
            exception <= 1'b0;
        end else if (accept_div) begin
            hi        <= '0;
            lo        <= mag_a;
            m         <= mag_b;
            neg       <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_ovf   <= (operand_a == INT_MIN) && (operand_b == ALL_ONES);
            iter_cnt  <= '0;
            result    <= '0;
            exception <= (operand_b == '0);
        end else begin
            case (state)
                ST_MULT: begin
                    hi       <= hi_nx;
                    lo       <= lo_nx;
                    qm1      <= lo[0];
                    iter_cnt <= iter_cnt + 6'd1;
                    if (last_iter) begin
                        result    <= lo_nx;
                        exception <= (hi_nx != {WIDTH{lo_nx[WIDTH-1]}});
                    end
                end
                ST_DIV: begin
                    hi       <= hi_nx;
                    lo       <= lo_nx;
                    iter_cnt <= iter_cnt + 6'd1;
                end
                ST_FIX: begin
                    lo        <= lo_nx;
                    result    <= lo_nx;
                    exception <= div_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: vector table plus hand-written corner sequences.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        op_mult, op_div;
    logic [31:0] operand_a, operand_b;
    logic [31:0] result;
    logic        exception, result_rdy, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .op_mult    (op_mult),
        .op_div     (op_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    typedef struct {
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op at cycle 0, optionally pulses op_div in cycle inj, then watches 45 cycles.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int inj,
                          output int rdy_cyc, output int rdy_cnt, output int busy_err,
                          output logic [31:0] res, output logic exc, output logic [31:0] res_end);
        @(negedge clock);
        op_mult   = m;
        op_div    = d;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        op_mult   = 1'b0;
        op_div    = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
        rdy_cyc   = -1;
        rdy_cnt   = 0;
        busy_err  = 0;
        res       = 'x;
        exc       = 1'bx;
        for (int c = 1; c <= 45; c++) begin
            op_div = (c == inj);
            if (busy !== (c <= lat)) busy_err++;
            if (result_rdy === 1'b1) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    res     = result;
                    exc     = exception;
                end
            end
            @(negedge clock);
        end
        op_div  = 1'b0;
        res_end = result;
    endtask

    int          rc, rn, be;
    logic [31:0] r, re;
    logic        e;

    initial begin
        vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        vecs[3]  = '{1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 34};
        vecs[4]  = '{1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        1'b0, 33};
        vecs[8]  = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33};
        vecs[10] = '{1'b0, 32'd100,        32'd7,         32'd14,        1'b0, 34};
        vecs[11] = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0, 34};
        vecs[12] = '{1'b0, 32'd7,          32'd100,       32'd0,         1'b0, 34};
        vecs[13] = '{1'b0, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, 34};
        vecs[14] = '{1'b1, 32'd1234,       32'd0,         32'd0,         1'b0, 33};

        reset_n   = 1'b0;
        op_mult   = 1'b0;
        op_div    = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clock);
        chk("reset result", result, 32'd0);
        chk("reset exception", exception, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset result_rdy", result_rdy, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b, vecs[i].lat, -1,
                   rc, rn, be, r, e, re);
            chk($sformatf("v%0d result", i), r, vecs[i].res);
            chk($sformatf("v%0d exception", i), e, vecs[i].exc);
            chk($sformatf("v%0d rdy cycle", i), rc, vecs[i].lat);
            chk($sformatf("v%0d rdy count", i), rn, 1);
            chk($sformatf("v%0d busy profile errors", i), be, 0);
            chk($sformatf("v%0d result held", i), re, vecs[i].res);
        end

        // Both ops together: multiply wins; op_div in cycle 10 is dropped.
        run_op(1'b1, 1'b1, 32'd6, 32'd3, 33, 10, rc, rn, be, r, e, re);
        chk("both-ops result", r, 32'd18);
        chk("both-ops exception", e, 1'b0);
        chk("both-ops rdy cycle", rc, 33);
        chk("both-ops rdy count", rn, 1);
        chk("both-ops busy profile errors", be, 0);
        chk("both-ops result held", re, 32'd18);

        // Reset while idle clears a held nonzero result immediately.
        reset_n = 1'b0;
        #1;
        chk("idle reset result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset in cycle 10 of a multiply aborts it with no strobe.
        @(negedge clock);
        op_mult   = 1'b1;
        operand_a = 32'd5;
        operand_b = 32'd5;
        @(negedge clock);
        op_mult = 1'b0;
        repeat (9) @(negedge clock);
        chk("mid-op busy before reset", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid-op reset busy", busy, 1'b0);
        chk("mid-op reset result_rdy", result_rdy, 1'b0);
        chk("mid-op reset result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rn = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_rdy === 1'b1 || busy === 1'b1) rn++;
            @(negedge clock);
        end
        chk("aborted op activity", rn, 0);

        run_op(1'b1, 1'b0, 32'd2, 32'd3, 33, -1, rc, rn, be, r, e, re);
        chk("post-reset result", r, 32'd6);
        chk("post-reset exception", e, 1'b0);
        chk("post-reset rdy cycle", rc, 33);
        chk("post-reset rdy count", rn, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Multi-cycle signed 32-bit multiply/divide sequencer for the ALU. It time-shares a single `cla_32` adder across 32 iterations: radix-2 Booth for multiply, restoring division on magnitudes for divide. It then raises a one-cycle `result_rdy` with the result and an exception flag. It sits beside the single-cycle ALU path and is started by decode with a one-cycle op pulse.

## Interface
- `WIDTH`, 32: operand and result width. Fixed at 32 by `cla_32`.
- `ITER`, 32: iteration count. Equals `WIDTH`.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `op_mult`  in  1  one-cycle start pulse for multiply.
- `op_div`  in  1  one-cycle start pulse for divide.
- `operand_a`  in  32  multiplicand or dividend, signed. Sampled at accept.
- `operand_b`  in  32  multiplier or divisor, signed. Sampled at accept.
- `result`  out  32  low product or quotient. Holds until the next accept.
- `exception`  out  1  overflow or divide-by-zero. Holds with `result`.
- `result_rdy`  out  1  one-cycle completion strobe.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE. On reset the state is IDLE and all outputs are 0.
- Accept happens only in IDLE.
  - If `op_mult` and `op_div` are both high, multiply wins.
  - Op pulses while `busy` are ignored and are not queued.
  - On accept: latch operands, clear the iteration counter, clear `result` and `exception`.
- MULT (Booth):
  - Register fields: hi[31:0], lo[31:0] (initialised to `operand_b`), q₋₁ = 0, and M = `operand_a`.
  - Each cycle, inspect {lo[0], q₋₁}:
    - 01: hi = hi + M.
    - 10: hi = hi + ~M with Cin = 1.
    - 00 or 11: no add.
  - Then arithmetic-shift {hi, lo, q₋₁} right by 1.
  - The sign bit shifted into hi is the 33-bit sum sign, a[31]^b_eff[31]^Cout. This keeps M = 0x80000000 correct.
  - After 32 iterations, go to DONE.
  - `result` = lo.
  - `exception` = 1 unless every bit of hi equals lo[31].
- DIV:
  - If divisor = 0 at accept, go directly to DONE with `result` = 0 and `exception` = 1.
  - Otherwise take magnitudes |a| and |b| with a dedicated negate at accept. Record neg = a[31]^b[31].
  - Remainder R[31:0] starts at 0. Q starts at |a|.
  - Each cycle:
    - Shift {R, Q} left by 1. Let `ov` be the bit shifted out of R.
    - Form R − |b| via `cla_32` (~|b|, Cin = 1).
    - If `ov` or Cout is set: R = difference, Q[0] = 1. Otherwise Q[0] = 0.
  - After 32 iterations, go to FIX.
- FIX: if neg, Q = 0 + ~Q + 1 via `cla_32`. Go to DONE.
  - Division truncates toward zero. Only the quotient is returned.
- Divide overflow: 0x80000000 / 0xFFFFFFFF gives `result` = 0x80000000 and `exception` = 1. This is detected at accept.
- DONE: assert `result_rdy` for one cycle, then return to IDLE.
- Reset asserted mid-operation:
  - State goes to IDLE and all outputs go to 0 immediately.
  - No `result_rdy` is produced for the aborted op.

## Timing
- The accepting op pulse is cycle 0.
- Multiply:
  - Iterations run in cycles 1–32.
  - `result_rdy` is high in cycle 33.
- Divide:
  - Iterations run in cycles 1–32.
  - FIX is cycle 33. It is always taken, even when neg = 0.
  - `result_rdy` is high in cycle 34.
- Divide by zero: `result_rdy` is high in cycle 1.
- `busy` is high from cycle 1 through the `result_rdy` cycle inclusive.
- A new op can be accepted in the cycle after `result_rdy`.
- `result` and `exception` are registered. They are valid in the `result_rdy` cycle and stable until the next accept.

## Structure
- Package `multdiv_pkg`:
  - state enum.
  - `ITER` = 32.
  - `INT_MIN` = 32'h8000_0000.
  - `ALL_ONES` = 32'hFFFF_FFFF.
- Instantiate exactly one `cla_32` as the shared adder. Its B/Cin mux is driven by state and the Booth bits. `bw_and`, `bw_or` and `isZero` are left unconnected.
- Use a 6-bit iteration counter. Terminal count is `ITER`−1.

## Test plan
- Multiply 7 × −3 (0xFFFFFFFD) → `result` 0xFFFFFFEB, `exception` 0, `result_rdy` in cycle 33 only.
- Multiply 0x00010000 × 0x00010000 → `result` 0, `exception` 1. Multiply 0x80000000 × 0xFFFFFFFF → `result` 0x80000000, `exception` 1.
- Divide −100 / 7 → `result` 0xFFFFFFF2 (−14), `exception` 0, `result_rdy` in cycle 34. Divide 100 / −7 → 0xFFFFFFF2.
- Divide 5 / 0 → `result` 0, `exception` 1, `result_rdy` in cycle 1. Divide 0x80000000 / 0xFFFFFFFF → 0x80000000, `exception` 1, `result_rdy` in cycle 34.
- `op_mult` and `op_div` together with 6, 3 → product 18 at cycle 33. An `op_div` pulsed in cycle 10 is ignored: no second `result_rdy`.
- `reset_n` low in cycle 10 of a multiply → `busy`, `result` and `result_rdy` go to 0 asynchronously. After release, multiply 2 × 3 → 6 at cycle 33.
